// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// IF stage of the 5-stage MIPS pipeline. It owns the fetch PC, the
// instruction-memory request handshake and the IF/ID pipeline register.
// Instruction memory may take any number of cycles to answer. A fetch that a
// redirect has made stale, while it is still outstanding, is drained and its
// word is discarded.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset_n      synchronous active-low reset
//   stallF       hold PC (hazard unit)
//   stallD       hold IF/ID register (hazard unit)
//   pcsrcD       taken branch resolved in D
//   pcbranchD    branch target
//   jumpD        jump in D (wins over pcsrcD)
//   pcjumpD      jump target
//   imem_req     fetch request, low only while reset_n=0
//   imem_addr    fetch address, always equal to pcF
//   imem_rdata   instruction word, valid when imem_ready=1
//   imem_ready   fetch completes this cycle
//   pcF          current fetch PC
//   instrD       IF/ID instruction
//   pcplus4D     IF/ID PC+4
//   validD       instrD is a real instruction, not a bubble
//   fetch_waitF  request outstanding and memory not ready (combinational)
//
// State table
//   state | meaning
//   RUN   | the outstanding fetch is for the current pcF
//   KILL  | the outstanding fetch is stale; redirectPc holds the new target
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  input  logic [31:0] pcjumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetch_waitF
);

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } stateT;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifidOpT;

  stateT       state;
  stateT       stateNext;
  ifidOpT      ifidOp;
  logic [31:0] redirectPc;
  logic [31:0] redirectPcNext;
  logic [31:0] pcNext;
  logic [31:0] pcPlus4F;
  logic [31:0] target;
  logic        redirect;

  // Branch operands are not ready while D is stalled, so a redirect seen
  // during a D stall is not trusted.
  assign redirect = (jumpD | pcsrcD) & ~stallD;
  assign target   = jumpD ? pcjumpD : pcbranchD;
  assign pcPlus4F = pcF + 32'd4;

  assign imem_req    = reset_n;
  assign imem_addr   = pcF;
  assign fetch_waitF = imem_req & ~imem_ready;

  // pcF only moves on a cycle where memory answers, so imem_addr stays
  // stable for the whole life of a request.
  always_comb begin
    stateNext      = state;
    pcNext         = pcF;
    redirectPcNext = redirectPc;
    ifidOp         = stallD ? IFID_HOLD : IFID_BUBBLE;

    case (state)
      RUN: begin
        if (imem_ready) begin
          if (redirect) begin
            // Returned word belongs to the wrong-path slot.
            pcNext = target;
          end else begin
            if (!stallF) pcNext = pcPlus4F;
            if (!stallD) ifidOp = IFID_LOAD;
          end
        end else if (redirect) begin
          redirectPcNext = target;
          stateNext      = KILL;
        end
      end

      KILL: begin
        if (redirect) redirectPcNext = target;
        if (imem_ready) begin
          // Stale word dropped; a same-cycle redirect is newer than
          // redirectPc. stallF does not block this load.
          pcNext    = redirect ? target : redirectPc;
          stateNext = RUN;
        end
      end

      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      pcF        <= RESET_PC;
      redirectPc <= 32'h0000_0000;
    end else begin
      state      <= stateNext;
      pcF        <= pcNext;
      redirectPc <= redirectPcNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instrD   <= NOP_INSTR;
      pcplus4D <= 32'h0000_0000;
      validD   <= 1'b0;
    end else begin
      case (ifidOp)
        IFID_LOAD: begin
          instrD   <= imem_rdata;
          pcplus4D <= pcPlus4F;
          validD   <= 1'b1;
        end
        IFID_BUBBLE: begin
          instrD   <= NOP_INSTR;
          pcplus4D <= 32'h0000_0000;
          validD   <= 1'b0;
        end
        default: begin
          instrD   <= instrD;
          pcplus4D <= pcplus4D;
          validD   <= validD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. Instruction memory returns an
// address-tagged word so a captured instruction identifies its fetch PC.
// A reference model of the IF stage, written from the stage's rules, runs in
// lock step with the DUT.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stallF;
  logic        stallD;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        jumpD;
  logic [31:0] pcjumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        fetch_waitF;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mP4;
  logic        mV;
  logic        mStale;
  logic [31:0] mRedir;

  // combinational outputs sampled mid-cycle, with their expectations
  logic [31:0] obsAddr;
  logic        obsReq;
  logic        obsWait;
  logic [31:0] expAddr;
  logic        expReq;
  logic        expWait;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = imem_ready ? memWord(imem_addr) : 32'hBADB_AD00;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stallF     (stallF),
    .stallD     (stallD),
    .pcsrcD     (pcsrcD),
    .pcbranchD  (pcbranchD),
    .jumpD      (jumpD),
    .pcjumpD    (pcjumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pcF        (pcF),
    .instrD     (instrD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .fetch_waitF(fetch_waitF)
  );

  // Drives one cycle of stimulus, advances the model and returns #1 after
  // the rising edge.
  task automatic step(input logic r, input logic sF, input logic sD,
                      input logic j, input logic b,
                      input logic [31:0] pj, input logic [31:0] pb,
                      input logic rd);
    logic        redir;
    logic [31:0] tgt;
    logic        hold;
    @(negedge clk);
    reset_n    = r;
    stallF     = sF;
    stallD     = sD;
    jumpD      = j;
    pcsrcD     = b;
    pcjumpD    = pj;
    pcbranchD  = pb;
    imem_ready = rd;
    #1;
    obsAddr = imem_addr;
    obsReq  = imem_req;
    obsWait = fetch_waitF;
    expAddr = mPc;
    expReq  = r;
    expWait = r & ~rd;

    redir = (j | b) & ~sD;
    tgt   = j ? pj : pb;
    hold  = sD;
    if (!r) begin
      mPc = 32'h0; mInstr = 32'h0; mP4 = 32'h0; mV = 1'b0;
      mStale = 1'b0; mRedir = 32'h0;
    end else begin
      if (!mStale && rd && !redir && !sD) begin
        mInstr = memWord(mPc);
        mP4    = mPc + 32'd4;
        mV     = 1'b1;
      end else if (!hold) begin
        mInstr = 32'h0; mP4 = 32'h0; mV = 1'b0;
      end
      if (!mStale) begin
        if (rd && redir)      mPc = tgt;
        else if (rd && !sF)   mPc = mPc + 32'd4;
        else if (!rd && redir) begin
          mRedir = tgt;
          mStale = 1'b1;
        end
      end else begin
        if (redir) mRedir = tgt;
        if (rd) begin
          mPc    = mRedir;
          mStale = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pcF, 32'h0); end
    checks++; if (instrD !== 32'h0) begin errors++; $display("FAIL reset_instr actual=%h required=%h", instrD, 32'h0); end
    checks++; if (pcplus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 actual=%h required=%h", pcplus4D, 32'h0); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", validD); end
    checks++; if (obsReq !== 1'b0) begin errors++; $display("FAIL reset_req actual=%b required=0", obsReq); end
    checks++; if (obsWait !== 1'b0) begin errors++; $display("FAIL reset_wait actual=%b required=0", obsWait); end
  endtask

  task automatic test_sequential();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (obsReq !== 1'b1) begin errors++; $display("FAIL seq_req actual=%b required=1", obsReq); end
    checks++; if (pcF !== 32'h4) begin errors++; $display("FAIL seq_pc4 actual=%h required=%h", pcF, 32'h4); end
    checks++; if (instrD !== memWord(32'h0)) begin errors++; $display("FAIL seq_instr0 actual=%h required=%h", instrD, memWord(32'h0)); end
    checks++; if (pcplus4D !== 32'h4) begin errors++; $display("FAIL seq_pcplus4 actual=%h required=%h", pcplus4D, 32'h4); end
    checks++; if (validD !== 1'b1) begin errors++; $display("FAIL seq_valid actual=%b required=1", validD); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'h8) begin errors++; $display("FAIL seq_pc8 actual=%h required=%h", pcF, 32'h8); end
    checks++; if (instrD !== memWord(32'h4)) begin errors++; $display("FAIL seq_instr4 actual=%h required=%h", instrD, memWord(32'h4)); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checks++; if (pcF !== 32'h8) begin errors++; $display("FAIL stall_pc cyc=%0d actual=%h required=%h", i, pcF, 32'h8); end
      checks++; if (instrD !== memWord(32'h4)) begin errors++; $display("FAIL stall_instr cyc=%0d actual=%h required=%h", i, instrD, memWord(32'h4)); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'hC) begin errors++; $display("FAIL stall_resume_pc actual=%h required=%h", pcF, 32'hC); end
    checks++; if (instrD !== memWord(32'h8)) begin errors++; $display("FAIL stall_resume_instr actual=%h required=%h", instrD, memWord(32'h8)); end
  endtask

  task automatic test_branch();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 1'b1);
    checks++; if (pcF !== 32'h40) begin errors++; $display("FAIL br_pc actual=%h required=%h", pcF, 32'h40); end
    checks++; if (validD !== 1'b0 || instrD !== 32'h0) begin errors++; $display("FAIL br_bubble actual=%b/%h required=0/00000000", validD, instrD); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (instrD !== memWord(32'h40) || validD !== 1'b1) begin errors++; $display("FAIL br_target_instr actual=%h/%b required=%h/1", instrD, validD, memWord(32'h40)); end
    checks++; if (pcF !== 32'h44) begin errors++; $display("FAIL br_next_pc actual=%h required=%h", pcF, 32'h44); end
  endtask

  task automatic test_kill();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    checks++; if (obsWait !== 1'b1) begin errors++; $display("FAIL kill_wait0 actual=%b required=1", obsWait); end
    checks++; if (pcF !== 32'h44 || validD !== 1'b0) begin errors++; $display("FAIL kill_hold0 actual=%h/%b required=%h/0", pcF, validD, 32'h44); end
    for (int i = 1; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (obsWait !== 1'b1) begin errors++; $display("FAIL kill_wait cyc=%0d actual=%b required=1", i, obsWait); end
      checks++; if (obsAddr !== 32'h44 || validD !== 1'b0) begin errors++; $display("FAIL kill_addr cyc=%0d actual=%h/%b required=%h/0", i, obsAddr, validD, 32'h44); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'h100) begin errors++; $display("FAIL kill_pc actual=%h required=%h", pcF, 32'h100); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL kill_drop actual=%b required=0", validD); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (instrD !== memWord(32'h100) || pcF !== 32'h104) begin errors++; $display("FAIL kill_after actual=%h/%h required=%h/%h", instrD, pcF, memWord(32'h100), 32'h104); end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 1'b1);
    checks++; if (pcF !== 32'h200) begin errors++; $display("FAIL prio_pc actual=%h required=%h", pcF, 32'h200); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h300, 1'b1);
    checks++; if (pcF !== 32'h200) begin errors++; $display("FAIL prio_stall_pc actual=%h required=%h", pcF, 32'h200); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL prio_stall_valid actual=%b required=0", validD); end
    // redirect during KILL on the ready cycle beats the stored target
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h600, 1'b1);
    checks++; if (pcF !== 32'h600) begin errors++; $display("FAIL prio_kill_pc actual=%h required=%h", pcF, 32'h600); end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    checks++; if (pcF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup actual=%h required=%h", pcF, 32'hFFFF_FFFC); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL wrap_pc actual=%h required=%h", pcF, 32'h0); end
    checks++; if (pcplus4D !== 32'h0 || validD !== 1'b1) begin errors++; $display("FAIL wrap_pcplus4 actual=%h/%b required=00000000/1", pcplus4D, validD); end
    checks++; if (instrD !== memWord(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr actual=%h required=%h", instrD, memWord(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid_fetch();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (obsReq !== 1'b0) begin errors++; $display("FAIL rmid_req actual=%b required=0", obsReq); end
    checks++; if (pcF !== 32'h0 || validD !== 1'b0) begin errors++; $display("FAIL rmid_state actual=%h/%b required=00000000/0", pcF, validD); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (pcF !== 32'h4 || instrD !== memWord(32'h0)) begin errors++; $display("FAIL rmid_restart actual=%h/%h required=%h/%h", pcF, instrD, 32'h4, memWord(32'h0)); end
  endtask

  task automatic test_random();
    logic r, st, j, b, rd;
    logic [31:0] pj, pb;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 4) == 0);
      j  = ($urandom_range(0, 9) == 0);
      b  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      pj = $urandom;
      pb = $urandom;
      step(r, st, st, j, b, pj, pb, rd);
      checks++; if (obsAddr !== expAddr) begin errors++; $display("FAIL rnd_addr cyc=%0d actual=%h required=%h", i, obsAddr, expAddr); end
      checks++; if (obsReq !== expReq || obsWait !== expWait) begin errors++; $display("FAIL rnd_req_wait cyc=%0d actual=%b%b required=%b%b", i, obsReq, obsWait, expReq, expWait); end
      checks++; if (pcF !== mPc) begin errors++; $display("FAIL rnd_pc cyc=%0d actual=%h required=%h", i, pcF, mPc); end
      checks++; if (instrD !== mInstr) begin errors++; $display("FAIL rnd_instr cyc=%0d actual=%h required=%h", i, instrD, mInstr); end
      checks++; if (pcplus4D !== mP4 || validD !== mV) begin errors++; $display("FAIL rnd_ifid cyc=%0d actual=%h/%b required=%h/%b", i, pcplus4D, validD, mP4, mV); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; stallF = 1'b0; stallD = 1'b0; jumpD = 1'b0; pcsrcD = 1'b0;
    pcjumpD = 32'h0; pcbranchD = 32'h0; imem_ready = 1'b0;
    mPc = 32'h0; mInstr = 32'h0; mP4 = 32'h0; mV = 1'b0; mStale = 1'b0; mRedir = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_kill();
    test_priority();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes stallF/stallD from the hazard unit and branch/jump redirects resolved in D.
- Produces instrD/pcplus4D for decode.
- Tolerates multi-cycle instruction memory. Discards a fetch made stale by a redirect while the fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding injected into instrD for bubbles (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- stallF  input  1  hold PC (from hazard unit).
- stallD  input  1  hold IF/ID register (from hazard unit).
- pcsrcD  input  1  taken branch resolved in D.
- pcbranchD  input  32  branch target.
- jumpD  input  1  jump in D.
- pcjumpD  input  32  jump target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, always equal to pcF.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- imem_ready  input  1  fetch complete this cycle.
- pcF  output  32  current fetch PC.
- instrD  output  32  IF/ID instruction.
- pcplus4D  output  32  IF/ID PC+4.
- validD  output  1  instrD is a real instruction, not a bubble.
- fetch_waitF  output  1  a request is outstanding and imem_ready=0.

Behaviour:
- Reset (reset_n=0 at posedge): pcF=RESET_PC, instrD=NOP_INSTR, pcplus4D=0, validD=0, state=RUN, redirect_pc=0. imem_req=0 combinationally while reset_n=0; otherwise imem_req=1 every cycle.
- imem_addr=pcF. It must stay stable from request until imem_ready=1. The PC therefore changes only in a cycle where imem_ready=1.
- redirect = (jumpD | pcsrcD) & ~stallD. Any jumpD/pcsrcD seen while stallD=1 is ignored, because the branch operands are not ready yet.
- Target priority: jumpD > pcsrcD, so target = jumpD ? pcjumpD : pcbranchD.
- All PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. No alignment check is made; the low 2 bits pass through.
- State RUN:
  - imem_ready=1 & redirect: pcF<=target; IF/ID gets a bubble; stay RUN. The returned word is dropped because it is the wrong-path slot.
  - imem_ready=1 & ~redirect & ~stallF: pcF<=pcF+4.
  - imem_ready=1 & ~redirect & ~stallD: IF/ID <= {imem_rdata, pcF+4, valid=1}.
  - imem_ready=1 & stallF: pcF holds and the fetch repeats next cycle; the word is not captured unless IF/ID loads it. The hazard unit always drives stallF=stallD.
  - imem_ready=0 & redirect: redirect_pc<=target; go to KILL; pcF holds; IF/ID gets a bubble.
  - imem_ready=0 & ~redirect: pcF holds; IF/ID gets a bubble unless stallD=1.
- State KILL (stale fetch outstanding):
  - IF/ID gets a bubble every cycle unless stallD=1.
  - Another redirect updates redirect_pc; the newest target wins.
  - On imem_ready=1: drop imem_rdata, pcF<=redirect_pc, go to RUN. A redirect arriving in the same cycle wins over redirect_pc, so pcF<=target.
  - stallF does not block the KILL→RUN PC load.
- IF/ID priority: reset > stallD (hold all fields) > bubble (instrD=NOP_INSTR, validD=0, pcplus4D=0) > load.
- fetch_waitF = imem_req & ~imem_ready. It is combinational and is OR'd into the stall sources upstream of the hazard unit.
- Reset mid-fetch: state is forced to RUN, and the outstanding response is treated as the response for RESET_PC. Memory must drop requests on reset.
- All outputs are registered, except imem_req, imem_addr (=pcF) and fetch_waitF.

Test Plan:
- Reset, then zero-wait memory returning addr-tagged words: pcF sequence 0,4,8,C. instrD lags one cycle, e.g. instrD=word@0 with pcplus4D=4, validD=1.
- stallF=stallD=1 for 2 cycles at pcF=8: pcF stays 8 and instrD stays word@4 for both cycles. The fetch resumes at 8, then 0xC.
- pcsrcD=1, pcbranchD=0x40, zero-wait: next pcF=0x40, then one bubble (validD=0, instrD=0), then instrD=word@0x40.
- Memory waits 3 cycles and jumpD=1 (pcjumpD=0x100) in the first wait cycle: state goes to KILL. fetch_waitF=1 for 3 cycles and the stale word is dropped. pcF=0x100 on the ready edge, with no validD=1 in between.
- jumpD=1 and pcsrcD=1 together (targets 0x200/0x300): pcF=0x200. Repeat with stallD=1: both are ignored and pcF holds.
- pcF=0xFFFF_FFFC with zero-wait memory: next pcF=0, and pcplus4D=0 with validD=1. Assert reset_n=0 during a 2-cycle wait: pcF=RESET_PC, validD=0 and imem_req=0 on the next edge.
